obi_fifo_mailbox: RTL and testbench



---
 rtl/obi_fifo_mailbox.sv | 177 +++++++++++++++++
 tb/tb_obi_fifo_mailbox.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/obi_fifo_mailbox.sv
// OBI word FIFO mailbox with a stream drain port; bus DATA pushes/pops words.
// OBI_FIFO_NONBLOCK_EN: never stall gnt, drop on full / flag on empty instead.
package obi_fifo_mailbox_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } sbr_obi_a_t;

  typedef struct packed {
    logic       req;
    sbr_obi_a_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } sbr_obi_r_t;

  typedef struct packed {
    logic       gnt;
    logic       rvalid;
    sbr_obi_r_t r;
  } sbr_obi_rsp_t;
endpackage

module obi_fifo_mailbox
  import obi_fifo_mailbox_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter logic [31:0] Magic = 32'h4D424F58
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  sbr_obi_req_t sbr_req_i,
  output sbr_obi_rsp_t sbr_rsp_o,
  output logic         stream_valid_o,
  input  logic         stream_ready_i,
  output logic [31:0]  stream_data_o,
  output logic         irq_o
);
  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = (AW+1)'(1);
  localparam logic [31:0] Dead = 32'hdeadbeef;

  logic [31:0] mem [Depth];
  logic [AW:0] rd_q, wr_q, cnt;
  logic        ovf_q, udf_q;
  logic        rvalid_q, err_q;
  logic [3:0]  rid_q;
  logic [31:0] rdata_q;

  logic [9:0]  idx;
  logic        we, empty, full;
  logic        is_data, is_stat, is_ctrl, is_magic;
  logic        data_wr, data_rd, stream_pop;
  logic        gnt, hs, push, bus_pop, flush;
  logic [31:0] status, rdata_d;
  logic        err_d;
  logic        unused_bits;

  assign idx = sbr_req_i.a.addr[11:2];
  assign we  = sbr_req_i.a.we;
  assign unused_bits = ^{sbr_req_i.a.addr[31:12],
                         sbr_req_i.a.addr[1:0],
                         sbr_req_i.a.be};

  assign empty = (rd_q == wr_q);
  assign full  = (rd_q[AW] != wr_q[AW]) &&
                 (rd_q[AW-1:0] == wr_q[AW-1:0]);
  assign cnt   = wr_q - rd_q;

  assign is_data  = (idx == 10'd0);
  assign is_stat  = (idx == 10'd1);
  assign is_ctrl  = (idx == 10'd2);
  assign is_magic = (idx == 10'd3);

  assign data_wr    = sbr_req_i.req && we && is_data;
  assign data_rd    = sbr_req_i.req && !we && is_data;
  assign stream_pop = stream_valid_o && stream_ready_i;

`ifdef OBI_FIFO_NONBLOCK_EN
  logic ovf_set, udf_set, clr;
  assign gnt     = !rst_i;
  assign ovf_set = hs && data_wr && full && !stream_pop;
  assign udf_set = hs && data_rd && (empty || stream_pop);
  assign clr     = hs && we && is_ctrl && sbr_req_i.a.wdata[1];
`else
  // Stall instead of dropping: full push waits, empty/contended pop waits.
  assign gnt = !rst_i &&
               !(data_wr && full && !stream_pop) &&
               !(data_rd && (empty || stream_pop));
  assign ovf_q = 1'b0;
  assign udf_q = 1'b0;
`endif

  assign hs      = sbr_req_i.req && gnt;
  assign push    = hs && data_wr && (!full || stream_pop);
  assign bus_pop = hs && data_rd && !empty && !stream_pop;
  assign flush   = hs && we && is_ctrl && sbr_req_i.a.wdata[0];

  assign status = {8'(AW), 4'b0, udf_q, ovf_q,
                   full, empty, 16'(cnt)};

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    unique case (1'b1)
      is_data:  if (!we) rdata_d = bus_pop ? mem[rd_q[AW-1:0]] : Dead;
      is_stat:  if (we) err_d = 1'b1; else rdata_d = status;
      is_ctrl:  if (!we) err_d = 1'b1;
      is_magic: if (we) err_d = 1'b1; else rdata_d = Magic;
      default: begin
        err_d   = 1'b1;
        rdata_d = Dead;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_q[AW-1:0]] <= sbr_req_i.a.wdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q     <= '0;
      wr_q     <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= hs;
      if (hs) begin
        rid_q   <= sbr_req_i.a.aid;
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
      // Flush overrides a same-cycle stream pop; that word counts as consumed.
      if (flush) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + PtrOne;
        if (stream_pop || bus_pop) rd_q <= rd_q + PtrOne;
      end
    end
  end

`ifdef OBI_FIFO_NONBLOCK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (clr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (udf_set) udf_q <= 1'b1;
    end
  end
`endif

  assign sbr_rsp_o.gnt     = gnt;
  assign sbr_rsp_o.rvalid  = rvalid_q;
  assign sbr_rsp_o.r.rdata = rdata_q;
  assign sbr_rsp_o.r.rid   = rid_q;
  assign sbr_rsp_o.r.err   = err_q;

  assign stream_valid_o = !empty;
  assign stream_data_o  = mem[rd_q[AW-1:0]];
  assign irq_o          = !empty || ovf_q || udf_q;
endmodule

// File: tb/tb_obi_fifo_mailbox.sv
// Directed bench for obi_fifo_mailbox with a response scoreboard.
// Covers both the blocking and OBI_FIFO_NONBLOCK_EN builds.
module tb_obi_fifo_mailbox;
  import obi_fifo_mailbox_pkg::*;

  localparam logic [31:0] MAGIC = 32'h4D424F58;
  localparam logic [31:0] DEAD  = 32'hdeadbeef;

  logic         clk = 1'b0;
  logic         rst;
  sbr_obi_req_t req;
  sbr_obi_rsp_t rsp;
  logic         sv, sr, irq;
  logic [31:0]  sd;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] got[$];
  logic        exp_rv;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  obi_fifo_mailbox dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sbr_req_i      (req),
    .sbr_rsp_o      (rsp),
    .stream_valid_o (sv),
    .stream_ready_i (sr),
    .stream_data_o  (sd),
    .irq_o          (irq)
  );

  function automatic void check(string tag, logic [31:0] obs,
                                logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) exp_rv <= 1'b0;
    else exp_rv <= req.req && rsp.gnt;

  always @(negedge clk) begin
    if (!rst) begin
      check("rvalid_lat", 32'(rsp.rvalid), 32'(exp_rv));
      if (rsp.rvalid) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("rdata", rsp.r.rdata, e.rdata);
          check("err", 32'(rsp.r.err), 32'(e.err));
          check("rid", 32'(rsp.r.rid), 32'(e.rid));
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst && sv && sr) got.push_back(sd);
  end

  task automatic drive(input logic we, input logic [9:0] idx,
                       input logic [31:0] wd, input logic [3:0] aid);
    req.req     = 1'b1;
    req.a.we    = we;
    req.a.addr  = {20'h0, idx, 2'b00};
    req.a.be    = 4'hf;
    req.a.wdata = wd;
    req.a.aid   = aid;
  endtask

  task automatic bus(input logic we, input logic [9:0] idx,
                     input logic [31:0] wd, input logic [3:0] aid,
                     input logic [31:0] erd, input logic eerr);
    int n = 0;
    drive(we, idx, wd, aid);
    #1;
    while (!rsp.gnt && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("gnt_timeout", 32'(rsp.gnt), 32'd1);
    if (rsp.gnt) sb.push_back('{erd, eerr, aid});
    @(negedge clk);
    req.req = 1'b0;
  endtask

  task automatic stall(input logic we, input logic [9:0] idx,
                       input logic [31:0] wd, input int cycles);
    drive(we, idx, wd, 4'h0);
    repeat (cycles) begin
      #1;
      check("stall_gnt", 32'(rsp.gnt), 32'd0);
      @(negedge clk);
    end
    req.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    sr  = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    check("rst_rvalid", 32'(rsp.rvalid), 32'd0);
    check("rst_sv", 32'(sv), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_gnt", 32'(rsp.gnt), 32'd0);
    check("rst_rdata", rsp.r.rdata, 32'd0);
    check("rst_rid", 32'(rsp.r.rid), 32'd0);
    check("rst_err", 32'(rsp.r.err), 32'd0);
    rst = 1'b0;

    bus(1'b0, 10'd3, 32'd0, 4'd5, MAGIC, 1'b0);
    bus(1'b0, 10'd1, 32'd0, 4'd6, 32'h03010000, 1'b0);

    for (int i = 0; i < 8; i++)
      bus(1'b1, 10'd0, 32'(32'h11 * (i + 1)), 4'(i), 32'd0, 1'b0);
    bus(1'b0, 10'd1, 32'd0, 4'd1, 32'h03020008, 1'b0);
`ifdef OBI_FIFO_NONBLOCK_EN
    bus(1'b1, 10'd0, 32'h99, 4'd2, 32'd0, 1'b0);
    bus(1'b0, 10'd1, 32'd0, 4'd3, 32'h03060008, 1'b0);
`else
    stall(1'b1, 10'd0, 32'h99, 3);
`endif

    for (int i = 0; i < 8; i++)
      bus(1'b0, 10'd0, 32'd0, 4'(i), 32'(32'h11 * (i + 1)), 1'b0);
`ifdef OBI_FIFO_NONBLOCK_EN
    bus(1'b0, 10'd1, 32'd0, 4'd4, 32'h03050000, 1'b0);
    check("irq_ovf", 32'(irq), 32'd1);
    bus(1'b1, 10'd2, 32'h2, 4'd4, 32'd0, 1'b0);
`endif
    bus(1'b0, 10'd1, 32'd0, 4'd4, 32'h03010000, 1'b0);
    check("irq_empty", 32'(irq), 32'd0);

    got.delete();
    sr = 1'b1;
    for (int i = 0; i < 16; i++)
      bus(1'b1, 10'd0, 32'(32'hA0 + i), 4'(i), 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    sr = 1'b0;
    check("stream_len", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < got.size()) check("stream_word", got[i], 32'(32'hA0 + i));
    bus(1'b0, 10'd1, 32'd0, 4'd7, 32'h03010000, 1'b0);

    bus(1'b1, 10'd0, 32'h55, 4'd1, 32'd0, 1'b0);
    bus(1'b1, 10'd0, 32'h66, 4'd2, 32'd0, 1'b0);
    got.delete();
    drive(1'b0, 10'd0, 32'd0, 4'd9);
    sr = 1'b1;
    #1;
`ifdef OBI_FIFO_NONBLOCK_EN
    check("conflict_gnt", 32'(rsp.gnt), 32'd1);
    sb.push_back('{DEAD, 1'b0, 4'd9});
    @(negedge clk);
    sr = 1'b0;
    req.req = 1'b0;
    bus(1'b0, 10'd1, 32'd0, 4'd3, 32'h03080001, 1'b0);
    bus(1'b0, 10'd0, 32'd0, 4'd4, 32'h66, 1'b0);
`else
    check("conflict_gnt", 32'(rsp.gnt), 32'd0);
    @(negedge clk);
    sr = 1'b0;
    #1;
    check("after_gnt", 32'(rsp.gnt), 32'd1);
    sb.push_back('{32'h66, 1'b0, 4'd9});
    @(negedge clk);
    req.req = 1'b0;
`endif
    check("pop_once_len", 32'(got.size()), 32'd1);
    if (got.size() != 0) check("pop_once_word", got[0], 32'h55);

    for (int i = 1; i <= 3; i++)
      bus(1'b1, 10'd0, 32'(i), 4'(i), 32'd0, 1'b0);
    bus(1'b0, 10'd1, 32'd0, 4'd5, 32'h03000003, 1'b0);
    bus(1'b1, 10'd2, 32'h3, 4'd6, 32'd0, 1'b0);
    bus(1'b0, 10'd1, 32'd0, 4'd7, 32'h03010000, 1'b0);
    check("irq_flush", 32'(irq), 32'd0);

    bus(1'b0, 10'd7, 32'd0, 4'd8, DEAD, 1'b1);
    bus(1'b1, 10'd3, 32'h1234, 4'd9, 32'd0, 1'b1);
    bus(1'b0, 10'd2, 32'd0, 4'd10, 32'd0, 1'b1);

    bus(1'b1, 10'd0, 32'h77, 4'd11, 32'd0, 1'b0);
    drive(1'b1, 10'd0, 32'h78, 4'd12);
    @(posedge clk);
    #2;
    check("mid_rvalid", 32'(rsp.rvalid), 32'd1);
    check("mid_sv", 32'(sv), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_drop_rvalid", 32'(rsp.rvalid), 32'd0);
    check("rst_drop_sv", 32'(sv), 32'd0);
    check("rst_drop_gnt", 32'(rsp.gnt), 32'd0);
    check("rst_drop_irq", 32'(irq), 32'd0);
    req.req = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus(1'b0, 10'd1, 32'd0, 4'd13, 32'h03010000, 1'b0);
    check("post_rst_sv", 32'(sv), 32'd0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
